// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request/response channels of the two requesters plus the shared ALU port.
interface alu_share_arb_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
);
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [OP_W-1:0]   req0_op, req1_op;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic              rsp0_valid, rsp1_valid;
    logic              rsp0_ready, rsp1_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_c;
    logic              alu_zero;

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_zero,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_c, alu_zero
    );

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_zero,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_c, alu_zero
    );
endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb: time-shares one single-cycle ALU between two requesters,
// registering the winning op and returning the captured result over valid/ready.
module alu_share_arb #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_share_arb_if.slave bus
);
    localparam logic [OP_W-1:0] ALU_NOP = '0;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d, own_q, own_d, zero_q, zero_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic              idle, sel1, fire0, fire1;

    always_comb begin
        idle = state_q == IDLE;
        // requester 1 wins when alone, or on a tie when 0 was served last
        sel1 = bus.req1_valid && (!bus.req0_valid || !last_q);
        bus.req0_ready = idle && (!bus.req1_valid || !sel1);
        bus.req1_ready = idle && (!bus.req0_valid || sel1);
        fire0 = bus.req0_valid && bus.req0_ready;
        fire1 = bus.req1_valid && bus.req1_ready;
        state_d = state_q;
        last_d  = last_q;
        own_d   = own_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: if (fire0 || fire1) begin
                own_d   = fire1;
                last_d  = fire1;
                op_d    = fire1 ? bus.req1_op : bus.req0_op;
                a_d     = fire1 ? bus.req1_a : bus.req0_a;
                b_d     = fire1 ? bus.req1_b : bus.req0_b;
                state_d = EXEC;
            end
            EXEC: begin
                data_d  = bus.alu_c;
                zero_d  = bus.alu_zero;
                state_d = RESP;
            end
            RESP: if (own_q ? bus.rsp1_ready : bus.rsp0_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        bus.rsp0_valid = state_q == RESP && !own_q;
        bus.rsp1_valid = state_q == RESP && own_q;
        bus.rsp_data   = data_q;
        bus.rsp_zero   = zero_q;
        bus.alu_op     = state_q == EXEC ? op_q : ALU_NOP;
        bus.alu_a      = state_q == EXEC ? a_q : '0;
        bus.alu_b      = state_q == EXEC ? b_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            own_q   <= 1'b0;
            op_q    <= ALU_NOP;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            own_q   <= own_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed checks of arbitration, latency, backpressure and reset
// against a behavioural ALU attached to the shared port.
module tb_alu_share_arb;
    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ALU_SLT  = 5'd10;
    localparam logic [4:0] ALU_SLTU = 5'd11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    alu_share_arb_if #(.DATA_W(32), .OP_W(5)) bus ();
    alu_share_arb #(.DATA_W(32), .OP_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always_comb begin
        case (bus.alu_op)
            ALU_ADD:  bus.alu_c = bus.alu_a + bus.alu_b;
            ALU_SUB:  bus.alu_c = bus.alu_a - bus.alu_b;
            ALU_OR:   bus.alu_c = bus.alu_a | bus.alu_b;
            ALU_SRA:  bus.alu_c = $signed(bus.alu_a) >>> bus.alu_b[4:0];
            ALU_SLT:  bus.alu_c = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            ALU_SLTU: bus.alu_c = {31'd0, bus.alu_a < bus.alu_b};
            default:  bus.alu_c = 32'd0;
        endcase
        bus.alu_zero = bus.alu_c == 32'd0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit p, input logic v, input logic [4:0] op, input logic [31:0] a, b);
        if (p) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    // Called just after a negedge in IDLE; returns just after a negedge back in IDLE.
    task automatic run(input bit p, input logic [4:0] op, input logic [31:0] a, b,
                       input logic [31:0] exp_c, input logic exp_z, input string tag);
        drive(p, 1'b1, op, a, b);
        #1;
        chk({tag, "_req_ready"}, p ? bus.req1_ready : bus.req0_ready, 1);
        @(posedge clk);
        #1;
        if (p) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_exec_op"}, bus.alu_op, op);
        chk({tag, "_exec_ab"}, {bus.alu_a, bus.alu_b}, {a, b});
        chk({tag, "_exec_rdy"}, {bus.req0_ready, bus.req1_ready}, 0);
        chk({tag, "_exec_rspv"}, {bus.rsp0_valid, bus.rsp1_valid}, 0);
        @(negedge clk);
        chk({tag, "_rspv"}, {bus.rsp0_valid, bus.rsp1_valid}, p ? 2'b01 : 2'b10);
        chk({tag, "_data"}, bus.rsp_data, exp_c);
        chk({tag, "_zero"}, bus.rsp_zero, exp_z);
        if (p) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, {bus.rsp0_valid, bus.rsp1_valid}, 0);
    endtask

    initial begin
        drive(0, 1'b0, ALU_NOP, 0, 0);
        drive(1, 1'b0, ALU_NOP, 0, 0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rspv", {bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk("rst_data", {bus.rsp_data, 31'd0, bus.rsp_zero}, 0);
        chk("rst_alu", {27'd0, bus.alu_op, bus.alu_a}, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b11);
        @(negedge clk);

        drive(0, 1'b1, ALU_ADD, 5, 7);
        #1;
        chk("lone0_ready1", bus.req1_ready, 0);
        run(0, ALU_ADD, 5, 7, 12, 0, "single_add");

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, ALU_SUB, 9, 9);
        drive(1, 1'b1, ALU_OR, 32'hF0, 32'h0F);
        #1;
        chk("tie1_ready", {bus.req0_ready, bus.req1_ready}, 2'b10);
        run(0, ALU_SUB, 9, 9, 0, 1, "tie1_sub");
        chk("tie1_pending_ready", {bus.req0_ready, bus.req1_ready}, 2'b01);
        run(1, ALU_OR, 32'hF0, 32'h0F, 32'hFF, 0, "tie1_or");
        drive(0, 1'b1, ALU_ADD, 1, 1);
        drive(1, 1'b1, ALU_ADD, 2, 2);
        #1;
        chk("tie2_ready", {bus.req0_ready, bus.req1_ready}, 2'b10);
        run(0, ALU_ADD, 1, 1, 2, 0, "tie2_r0");
        run(1, ALU_ADD, 2, 2, 4, 0, "tie2_r1");

        run(1, ALU_SLT, 32'hFFFFFFFF, 1, 1, 0, "slt");
        run(0, ALU_SLTU, 32'hFFFFFFFF, 1, 0, 1, "sltu");
        run(1, ALU_SRA, 32'h80000000, 4, 32'hF8000000, 0, "sra");

        drive(0, 1'b1, ALU_ADD, 3, 4);
        @(posedge clk);
        #1;
        drive(0, 1'b0, ALU_NOP, 32'hDEAD, 32'hBEEF);
        @(negedge clk);
        @(negedge clk);
        bus.req1_valid = 1'b1;
        bus.rsp1_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rspv", {bus.rsp0_valid, bus.rsp1_valid}, 2'b10);
            chk("bp_data", bus.rsp_data, 7);
            chk("bp_ready", {bus.req0_ready, bus.req1_ready}, 0);
            @(negedge clk);
        end
        bus.req1_valid = 1'b0;
        bus.rsp1_ready = 1'b0;
        bus.rsp0_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp0_ready = 1'b0;
        @(negedge clk);
        chk("bp_release", {bus.rsp0_valid, bus.rsp1_valid, bus.req0_ready, bus.req1_ready}, 4'b0011);

        drive(0, 1'b1, ALU_ADD, 20, 22);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("mid_exec_op", bus.alu_op, ALU_ADD);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rspv", {bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk("mid_rst_data", {bus.rsp_data, 31'd0, bus.rsp_zero}, 0);
        chk("mid_rst_alu", {27'd0, bus.alu_op, bus.alu_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp0_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 0);
        end
        bus.rsp0_ready = 1'b0;
        drive(0, 1'b1, ALU_ADD, 0, 0);
        drive(1, 1'b1, ALU_ADD, 0, 0);
        #1;
        chk("mid_last_reset", {bus.req0_ready, bus.req1_ready}, 2'b10);
        bus.req0_valid = 1'b0;
        run(1, ALU_SUB, 100, 58, 42, 0, "after_rst_r1");

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_op", bus.alu_op, ALU_NOP);
            chk("idle_ab", {bus.alu_a, bus.alu_b}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
